// File: rtl/booth_radix4_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: two multiplier bits retired per clock, registered 2*WIDTH product.
// Optional BOOTH_UNSIGNED_EN: honour is_signed (zero-extend operands when 0); otherwise operands are always signed.
module booth_radix4_seq_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);

    localparam int EXT       = WIDTH + 2;
    localparam int NUM_STEPS = EXT / 2;
    localparam int CNT_W     = $clog2(NUM_STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        CALCULATING = 2'b01,
        DONE        = 2'b10
    } stateT;

    stateT                   state;
    logic signed [EXT-1:0]   mcand;
    logic [EXT:0]            yWin;
    logic signed [2*EXT-1:0] acc;
    logic signed [2*EXT-1:0] accShifted;
    logic signed [2*EXT-1:0] ppWide;
    logic signed [2*EXT-1:0] accNext;
    logic signed [EXT-1:0]   pp;
    logic [CNT_W-1:0]        stepCount;
    logic                    extM;
    logic                    extY;

`ifdef BOOTH_UNSIGNED_EN
    assign extM = is_signed & multiplicand[WIDTH-1];
    assign extY = is_signed & multiplier[WIDTH-1];
`else
    logic unusedIsSigned;
    assign unusedIsSigned = is_signed;
    assign extM = multiplicand[WIDTH-1];
    assign extY = multiplier[WIDTH-1];
`endif

    // Booth digit selection; the E-bit width leaves headroom so +/-2M never overflows.
    function automatic logic signed [EXT-1:0] boothPartial(input logic [2:0] win,
                                                          input logic signed [EXT-1:0] m);
        case (win)
            3'b000, 3'b111: return {EXT{1'b0}};
            3'b001, 3'b010: return m;
            3'b011:         return m <<< 1;
            3'b100:         return -(m <<< 1);
            3'b101, 3'b110: return -m;
            default:        return {EXT{1'b0}};
        endcase
    endfunction

    assign busy = (state == CALCULATING);
    assign done = (state == DONE);

    // Next accumulator value: arithmetic shift by two, partial product added at the top.
    always_comb begin
        pp         = boothPartial(yWin[2:0], mcand);
        accShifted = acc >>> 2;
        ppWide     = {{2{pp[EXT-1]}}, pp, {(EXT-2){1'b0}}};
        accNext    = accShifted + ppWide;
    end

    // Controller, operand latches, accumulator and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            result    <= '0;
            acc       <= '0;
            stepCount <= '0;
            mcand     <= '0;
            yWin      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand     <= {{2{extM}}, multiplicand};
                        yWin      <= {{2{extY}}, multiplier, 1'b0};
                        acc       <= '0;
                        stepCount <= '0;
                        state     <= CALCULATING;
                    end
                end
                CALCULATING: begin
                    acc       <= accNext;
                    yWin      <= yWin >> 2;
                    stepCount <= stepCount + CNT_W'(1);
                    if (stepCount == LAST_STEP) begin
                        result <= accNext[2*WIDTH-1:0];
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq_multiplier.sv
// Self-checking bench for booth_radix4_seq_multiplier: WIDTH=8 and WIDTH=64 instances, directed and random cases.
module tb_booth_radix4_seq_multiplier;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        start8 = 1'b0, signed8 = 1'b1;
    logic [7:0]  mcand8 = 8'd0, mplier8 = 8'd0;
    logic [15:0] result8;
    logic        busy8, done8;

    logic         start64 = 1'b0, signed64 = 1'b1;
    logic [63:0]  mcand64 = 64'd0, mplier64 = 64'd0;
    logic [127:0] result64;
    logic         busy64, done64;

    int checks = 0;
    int failures = 0;

    booth_radix4_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(signed8),
        .multiplicand(mcand8), .multiplier(mplier8),
        .result(result8), .busy(busy8), .done(done8));

    booth_radix4_seq_multiplier #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .is_signed(signed64),
        .multiplicand(mcand64), .multiplier(mplier64),
        .result(result64), .busy(busy64), .done(done64));

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: extend both operands to 128 bits per mode, multiply, keep 2*w bits.
    function automatic logic [127:0] refProduct(input int w, input logic [63:0] m, input logic [63:0] y,
                                                input logic sgn);
        logic [127:0] mask, a, b, p;
        logic useSigned;
`ifdef BOOTH_UNSIGNED_EN
        useSigned = sgn;
`else
        useSigned = 1'b1;
`endif
        mask = (128'd1 << w) - 128'd1;
        a = {64'd0, m} & mask;
        b = {64'd0, y} & mask;
        if (useSigned && a[w-1]) a = a | ~mask;
        if (useSigned && b[w-1]) b = b | ~mask;
        p = a * b;
        return p & ((128'd1 << (2 * w)) - 128'd1);
    endfunction

    task automatic run8(input logic [7:0] m, input logic [7:0] y, input logic sgn, input int injectAt,
                        input logic [7:0] m2, input logic [7:0] y2, output int lat);
        @(negedge clk);
        start8 = 1'b1; mcand8 = m; mplier8 = y; signed8 = sgn;
        @(negedge clk);
        lat = 0;
        while (busy8 && lat < 100) begin
            lat++;
            if (lat == injectAt) begin
                start8 = 1'b1; mcand8 = m2; mplier8 = y2;
            end else begin
                start8 = 1'b0; mcand8 = 8'($urandom); mplier8 = 8'($urandom);
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        checkEq("done8", {127'd0, done8}, 128'd1);
        checkEq("busy8_off", {127'd0, busy8}, 128'd0);
    endtask

    task automatic run64(input logic [63:0] m, input logic [63:0] y, input logic sgn, output int lat);
        @(negedge clk);
        start64 = 1'b1; mcand64 = m; mplier64 = y; signed64 = sgn;
        @(negedge clk);
        lat = 0;
        while (busy64 && lat < 200) begin
            lat++;
            start64 = 1'b0; mcand64 = {$urandom, $urandom}; mplier64 = {$urandom, $urandom};
            @(negedge clk);
        end
        start64 = 1'b0;
        checkEq("done64", {127'd0, done64}, 128'd1);
    endtask

    initial begin
        int lat;
        logic [7:0] m8, y8;
        logic [63:0] m64, y64;
        logic s;

        #2 reset = 1'b1;
        #10;
        checkEq("rst_result8", {112'd0, result8}, 128'd0);
        checkEq("rst_busy8", {127'd0, busy8}, 128'd0);
        checkEq("rst_done8", {127'd0, done8}, 128'd0);
        checkEq("rst_result64", result64, 128'd0);
        checkEq("rst_flags64", {126'd0, busy64, done64}, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        run8(8'h80, 8'h80, 1'b1, 0, 8'h00, 8'h00, lat);
        checkEq("neg128sq", {112'd0, result8}, 128'h4000);
        checkEq("neg128sq_lat", 128'(lat), 128'd5);

        run8(8'hFF, 8'hFF, 1'b0, 0, 8'h00, 8'h00, lat);
`ifdef BOOTH_UNSIGNED_EN
        checkEq("ff_unsigned", {112'd0, result8}, 128'hFE01);
`else
        checkEq("ff_unsigned", {112'd0, result8}, 128'h0001);
`endif
        run8(8'hFF, 8'hFF, 1'b1, 0, 8'h00, 8'h00, lat);
        checkEq("ff_signed", {112'd0, result8}, 128'h0001);

        run64(64'h7FFFFFFFFFFFFFFF, 64'h8000000000000000, 1'b1, lat);
        checkEq("max_x_min64", result64, 128'hC0000000000000008000000000000000);
        checkEq("max_x_min64_lat", 128'(lat), 128'd33);
        run64(64'd0, {$urandom, $urandom}, 1'b1, lat);
        checkEq("zero64", result64, 128'd0);

        // Back-to-back: start held in DONE, old result must hold until new completion.
        run8(8'd3, 8'd5, 1'b1, 0, 8'h00, 8'h00, lat);
        checkEq("b2b_first", {112'd0, result8}, 128'h000F);
        start8 = 1'b1; mcand8 = 8'd7; mplier8 = 8'hFA;
        @(negedge clk);
        start8 = 1'b0;
        checkEq("b2b_busy", {127'd0, busy8}, 128'd1);
        checkEq("b2b_done_drop", {127'd0, done8}, 128'd0);
        lat = 0;
        while (busy8 && lat < 100) begin
            lat++;
            checkEq("b2b_hold", {112'd0, result8}, 128'h000F);
            @(negedge clk);
        end
        checkEq("b2b_second", {112'd0, result8}, 128'hFFD6);
        checkEq("b2b_lat", 128'(lat), 128'd5);
        checkEq("b2b_done", {127'd0, done8}, 128'd1);

        // start mid-calculation with other operands is ignored.
        run8(8'd25, 8'hF3, 1'b1, 2, 8'd99, 8'd77, lat);
        checkEq("midstart", {112'd0, result8}, refProduct(8, 64'd25, 64'hF3, 1'b1));
        checkEq("midstart_lat", 128'(lat), 128'd5);

        // Asynchronous reset during step 2.
        @(negedge clk);
        start8 = 1'b1; mcand8 = 8'd100; mplier8 = 8'hFD; signed8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkEq("arst_result", {112'd0, result8}, 128'd0);
        checkEq("arst_busy", {127'd0, busy8}, 128'd0);
        checkEq("arst_done", {127'd0, done8}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        run8(8'd100, 8'hFD, 1'b1, 0, 8'h00, 8'h00, lat);
        checkEq("post_rst", {112'd0, result8}, 128'hFED4);
        checkEq("post_rst_lat", 128'(lat), 128'd5);

        for (int i = 0; i < 20; i++) begin
            m8 = 8'($urandom); y8 = 8'($urandom); s = 1'($urandom);
            run8(m8, y8, s, 0, 8'h00, 8'h00, lat);
            checkEq("rand8", {112'd0, result8}, refProduct(8, {56'd0, m8}, {56'd0, y8}, s));
            checkEq("rand8_lat", 128'(lat), 128'd5);
        end
        for (int i = 0; i < 8; i++) begin
            m64 = {$urandom, $urandom}; y64 = {$urandom, $urandom}; s = 1'($urandom);
            run64(m64, y64, s, lat);
            checkEq("rand64", result64, refProduct(64, m64, y64, s));
            checkEq("rand64_lat", 128'(lat), 128'd33);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_radix4_seq_multiplier.md
# booth_radix4_seq_multiplier

Parametrised sequential radix-4 Booth multiplier core: accepts two WIDTH-bit operands on a start pulse, retires two multiplier bits per clock, and presents a registered 2*WIDTH-bit product with a done flag. It generalises the fixed 64-bit accumulate-and-shift datapath (result ASR 2 plus shifted partial product) into a complete self-sequencing unit with its own controller, iteration counter and start/done handshake. Signed/unsigned mode selection is optional.

## Interface
- WIDTH, 64, operand width; even, >= 4
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned (see Configuration)
- multiplicand  input  WIDTH  M, sampled with start
- multiplier  input  WIDTH  Y, sampled with start
- result  output  2*WIDTH  product, registered
- busy  output  1  high while in CALCULATING
- done  output  1  high while in DONE

## Operation
- States (2-bit): IDLE=00, CALCULATING=01, DONE=10; 11 unreachable, decodes to IDLE on next edge.
- Extended width E = WIDTH+2; iteration count N = E/2 = WIDTH/2+1; counter width ceil(log2(N+1)).
- Start accepted (IDLE or DONE): M and Y extended to E bits (sign- or zero-extended per mode), latched; accumulator (2E bits, signed) cleared; counter = 0; state -> CALCULATING.
- Step i (0..N-1), one per edge in CALCULATING: digit from bits (Y[2i+1], Y[2i], Y[2i-1]), Y[-1]=0; map 000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M. pp = digit*M, E-bit signed (never overflows).
- Update: acc <= (acc >>> 2) + (pp << (E-2)), 2E-bit arithmetic, carries out of bit 2E-1 discarded.
- After step N-1: result <= acc[2*WIDTH-1:0]; state -> DONE. result changes only at this edge.
- DONE: result held, done=1; stays until a new start is accepted; result keeps old value until the next completion.
- start during CALCULATING: ignored, no effect on operands or counter.
- Operand inputs outside the start-accept edge: don't-care.

## Timing
- Reset values: state IDLE, result 0, acc 0, counter 0, busy 0, done 0; reset mid-calculation aborts immediately, no partial result exposed.
- Start sampled at edge 0; busy=1 after edge 0; steps at edges 1..N; done=1 and result valid after edge N. WIDTH=64 -> N=33; WIDTH=8 -> N=5.
- Back-to-back: start high in DONE at edge k -> busy after edge k, done drops same edge; new result after edge k+N.
- done and busy are never simultaneously high; both are decoded directly from state register (no combinational path from inputs).

## Configuration
- BOOTH_UNSIGNED_EN defined: is_signed honoured; 0 zero-extends M and Y to E bits, 1 sign-extends.
- Undefined: is_signed ignored, operands always sign-extended; port remains present; E, N, latency unchanged.

## Test plan
- WIDTH=8, signed: M=-128 (0x80), Y=-128 -> result 0x4000 after exactly 5 steps; busy high 5 cycles, then done.
- WIDTH=8, BOOTH_UNSIGNED_EN, is_signed=0: M=0xFF, Y=0xFF -> 0xFE01; same operands is_signed=1 -> 0x0001; without macro, is_signed=0 still -> 0x0001.
- WIDTH=64, signed: M=0x7FFFFFFFFFFFFFFF, Y=0x8000000000000000 -> 0xC0000000000000008000000000000000 after 33 steps; M=0, Y=any -> 0.
- Back-to-back: 3*5 then start held in DONE with 7*(-6) (WIDTH=8) -> 0x000F, then 0xFFD6; result holds 0x000F throughout second calculation.
- start pulsed mid-CALCULATING with different operands -> ignored, original product returned on schedule.
- reset asserted asynchronously at step 2 -> result 0, busy 0, done 0 immediately; next start yields correct product with full latency.
